// File: rtl/axil_mem_slave_v2.sv
// axil_mem_slave_v2: AXI4-Lite memory slave with byte strobes, range
// checking, independent AW/W capture, wait states and a write-notify port.
module axil_mem_slave_v2 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 0,
    parameter int WR_LAT = 0
) (
    input  logic                AXI_ACLK,
    input  logic                AXI_ARESETN,
    input  logic [ADDR_W-1:0]   AXI_AWADDR,
    input  logic                AXI_AWVALID,
    output logic                AXI_AWREADY,
    input  logic [DATA_W-1:0]   AXI_WDATA,
    input  logic [DATA_W/8-1:0] AXI_WSTRB,
    input  logic                AXI_WVALID,
    output logic                AXI_WREADY,
    output logic [1:0]          AXI_BRESP,
    output logic                AXI_BVALID,
    input  logic                AXI_BREADY,
    input  logic [ADDR_W-1:0]   AXI_ARADDR,
    input  logic                AXI_ARVALID,
    output logic                AXI_ARREADY,
    output logic [DATA_W-1:0]   AXI_RDATA,
    output logic [1:0]          AXI_RRESP,
    output logic                AXI_RVALID,
    input  logic                AXI_RREADY,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [DATA_W-1:0]   mem_wr_data
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      WR_LAT_C = 4'(WR_LAT);
    localparam logic [3:0]      RD_LAT_C = 4'(RD_LAT);
    localparam logic [1:0]      OKAY     = 2'b00;
    localparam logic [1:0]      SLVERR   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_e          w_state_q, w_state_d;
    logic              aw_have_q, aw_have_d;
    logic              w_have_q, w_have_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [ADDR_W:0]   w_idx, r_idx;
    logic              w_in_range, r_in_range, w_commit;
    logic [DATA_W-1:0] wr_word, rd_word;

    assign w_idx      = (ADDR_W+1)'(awaddr_q >> OFF);
    assign r_idx      = (ADDR_W+1)'(araddr_q >> OFF);
    assign w_in_range = w_idx < DEPTH_C;
    assign r_in_range = r_idx < DEPTH_C;
    assign w_commit   = (w_state_q == W_WAIT) && (wcnt_q == WR_LAT_C);
    assign rd_word    = mem[r_idx[IDX_W-1:0]];

    // Merged word feeds both the array and the notify port.
    always_comb begin
        wr_word = mem[w_idx[IDX_W-1:0]];
        for (int k = 0; k < STRB_W; k++) begin
            if (wstrb_q[k]) wr_word[8*k +: 8] = wdata_q[8*k +: 8];
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (w_commit && w_in_range) mem[w_idx[IDX_W-1:0]] <= wr_word;
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wcnt_d    = wcnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_wr_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (AXI_AWVALID && awready_q) begin
                    aw_have_d = 1'b1;
                    awaddr_d  = AXI_AWADDR;
                end
                if (AXI_WVALID && wready_q) begin
                    w_have_d = 1'b1;
                    wdata_d  = AXI_WDATA;
                    wstrb_d  = AXI_WSTRB;
                end
                if (aw_have_d && w_have_d) begin
                    w_state_d = W_WAIT;
                    wcnt_d    = '0;
                end
            end
            W_WAIT: begin
                if (w_commit) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = w_in_range ? OKAY : SLVERR;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    if (w_in_range) begin
                        mem_wr_d  = 1'b1;
                        wr_addr_d = awaddr_q;
                        wr_data_d = wr_word;
                    end
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            W_RESP: begin
                if (AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_have_d;
        wready_d  = (w_state_d == W_IDLE) && !w_have_d;
    end

    // Memory is sampled on the RVALID-rise edge, so a same-edge commit is not seen.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (AXI_ARVALID && arready_q) begin
                    r_state_d = R_WAIT;
                    araddr_d  = AXI_ARADDR;
                    rcnt_d    = '0;
                end
            end
            R_WAIT: begin
                if (rcnt_q == RD_LAT_C) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                    rresp_d   = r_in_range ? OKAY : SLVERR;
                    rdata_d   = r_in_range ? rd_word : '0;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            R_RESP: begin
                if (AXI_RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    rresp_d   = OKAY;
                    rdata_d   = '0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wcnt_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            mem_wr_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wcnt_q    <= wcnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            mem_wr_q  <= mem_wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = arready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RRESP   = rresp_q;
    assign AXI_RDATA   = rdata_q;
    assign mem_wr      = mem_wr_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_axil_mem_slave_v2.sv
// Directed bench for axil_mem_slave_v2 (DEPTH=64, WR_LAT=0, RD_LAT=3).
// Outputs are sampled 1ns after each rising edge.
module tb_axil_mem_slave_v2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, mem_wr_data;
    logic        mem_wr;
    logic [8:0]  mem_wr_addr;
    logic [82:0] outs;

    int total = 0;
    int bad   = 0;

    logic [1:0]  resp;
    logic [31:0] d, pd;
    logic [8:0]  pa;
    logic        pulse;
    int          lat;

    always #5 clk = ~clk;

    axil_mem_slave_v2 #(
        .DATA_W(32), .ADDR_W(9), .DEPTH(64), .RD_LAT(3), .WR_LAT(0)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid),
        .AXI_WREADY(wready), .AXI_BRESP(bresp), .AXI_BVALID(bvalid),
        .AXI_BREADY(bready), .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid),
        .AXI_ARREADY(arready), .AXI_RDATA(rdata), .AXI_RRESP(rresp),
        .AXI_RVALID(rvalid), .AXI_RREADY(rready), .mem_wr(mem_wr),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    assign outs = {awready, wready, bresp, bvalid, arready, rdata, rresp,
                   rvalid, mem_wr, mem_wr_addr, mem_wr_data};

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] dd,
                      input logic [3:0] s, output logic [1:0] r,
                      output int l, output logic p,
                      output logic [8:0] xa, output logic [31:0] xd);
        int n;
        awaddr = a; wdata = dd; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        l = 0;
        while (!bvalid && l < 20) begin tick(); l++; end
        r = bresp; p = mem_wr; xa = mem_wr_addr; xd = mem_wr_data;
        tick();
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] dd,
                      output logic [1:0] r, output int l);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        l = 0;
        while (!rvalid && l < 30) begin tick(); l++; end
        dd = rdata; r = rresp;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        #1;
        chk("reset_outs", 96'(outs), 96'(0));
        tick(); tick();
        chk("reset_outs_held", 96'(outs), 96'(0));
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 96'({awready, wready, arready}), 96'(3'b111));

        wr(9'h010, 32'hDEADBEEF, 4'hF, resp, lat, pulse, pa, pd);
        chk("t1_b_lat", 96'(lat), 96'(1));
        chk("t1_bresp", 96'(resp), 96'(2'b00));
        chk("t1_notify", 96'({pulse, pa, pd}), 96'({1'b1, 9'h010, 32'hDEADBEEF}));
        rd(9'h010, d, resp, lat);
        chk("t1_r_lat", 96'(lat), 96'(4));
        chk("t1_rdata", 96'({resp, d}), 96'({2'b00, 32'hDEADBEEF}));

        wdata = 32'h0000CAFE; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("t2_w_held", 96'({awready, wready, bvalid}), 96'(3'b100));
        tick(); tick();
        awaddr = 9'h010; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t2_in_wait", 96'({awready, wready, bvalid}), 96'(3'b000));
        tick();
        chk("t2_b", 96'({bvalid, bresp, mem_wr, mem_wr_addr, mem_wr_data}),
            96'({1'b1, 2'b00, 1'b1, 9'h010, 32'hDEADCAFE}));
        tick();
        chk("t2_b_done", 96'({bvalid, mem_wr, awready}), 96'(3'b001));
        rd(9'h013, d, resp, lat);
        chk("t2_rdata_lowbits", 96'({resp, d}), 96'({2'b00, 32'hDEADCAFE}));

        wr(9'h1FC, 32'h12345678, 4'hF, resp, lat, pulse, pa, pd);
        chk("t3_b_lat", 96'(lat), 96'(1));
        chk("t3_slverr", 96'({resp, pulse}), 96'({2'b10, 1'b0}));
        rd(9'h1FC, d, resp, lat);
        chk("t3_r_lat", 96'(lat), 96'(4));
        chk("t3_rslverr", 96'({resp, d}), 96'({2'b10, 32'h0}));

        wr(9'h040, 32'h0F0F0F0F, 4'hF, resp, lat, pulse, pa, pd);
        wr(9'h040, 32'hFFFFFFFF, 4'h0, resp, lat, pulse, pa, pd);
        chk("strb0", 96'({resp, pulse, pa, pd}),
            96'({2'b00, 1'b1, 9'h040, 32'h0F0F0F0F}));
        wr(9'h040, 32'hA5A5A5A5, 4'hA, resp, lat, pulse, pa, pd);
        chk("strb_a", 96'({resp, pulse, pd}), 96'({2'b00, 1'b1, 32'hA50FA50F}));
        rd(9'h040, d, resp, lat);
        chk("strb_rd", 96'({resp, d}), 96'({2'b00, 32'hA50FA50F}));

        rready = 1'b0;
        araddr = 9'h010; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wait", 96'({rvalid, arready, rdata}), 96'(0));
        end
        tick();
        chk("t4_rise", 96'({rvalid, arready, rresp, rdata}),
            96'({1'b1, 1'b0, 2'b00, 32'hDEADCAFE}));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_hold", 96'({rvalid, arready, rresp, rdata}),
                96'({1'b1, 1'b0, 2'b00, 32'hDEADCAFE}));
        end
        rready = 1'b1;
        tick();
        chk("t4_done", 96'({rvalid, rdata, arready}), 96'({1'b0, 32'h0, 1'b1}));

        wr(9'h020, 32'h11223344, 4'hF, resp, lat, pulse, pa, pd);
        awaddr = 9'h020; wdata = 32'h00000055; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t5_in_wait", 96'({awready, wready, bvalid}), 96'(3'b000));
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outs", 96'(outs), 96'(0));
        tick();
        chk("t5_reset_held", 96'(outs), 96'(0));
        rst_n = 1'b1;
        tick(); tick();
        chk("t5_after", 96'({bvalid, mem_wr, awready, wready, arready}),
            96'(5'b00111));
        rd(9'h020, d, resp, lat);
        chk("t5_prior", 96'({resp, d}), 96'({2'b00, 32'h11223344}));

        wr(9'h030, 32'hAAAA0000, 4'hF, resp, lat, pulse, pa, pd);
        araddr = 9'h030; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick(); tick();
        awaddr = 9'h030; wdata = 32'hBBBBBBBB; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("t6_same_cycle", 96'({rvalid, bvalid, mem_wr, rdata}),
            96'({3'b111, 32'hAAAA0000}));
        tick();
        rd(9'h030, d, resp, lat);
        chk("t6_next_read", 96'({resp, d}), 96'({2'b00, 32'hBBBBBBBB}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
